// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_port
// Description : Master-side serial port for the system bus. Takes one parallel
//               read/write request, shifts the device address to the address
//               decoder, waits for ack, then shifts the slave memory address
//               and write data or collects serial read data.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_master_port #(
  parameter int ADDR_WIDTH        = 16,
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  mwdata,
  output logic                  mvalid,
  output logic                  mmode,
  input  logic                  ack,
  input  logic                  mrdata,
  input  logic                  svalid
);

  localparam int MEM_WIDTH = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
  localparam int MAX_A     = (DEVICE_ADDR_WIDTH > MEM_WIDTH) ? DEVICE_ADDR_WIDTH : MEM_WIDTH;
  localparam int MAX_W     = (MAX_A > DATA_WIDTH) ? MAX_A : DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(MAX_W) + 1;

  localparam logic [CNT_WIDTH-1:0] DEV_LAST  = CNT_WIDTH'(DEVICE_ADDR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] MEM_LAST  = CNT_WIDTH'(MEM_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DADDR = 3'd1,
    S_WACK  = 3'd2,
    S_SADDR = 3'd3,
    S_WDATA = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0]  rbuf, rbuf_n;
  logic                   mode_n;
  logic                   accept;

  logic                   dready_n;
  logic                   ddone_n;
  logic                   mvalid_n;
  logic                   mwdata_n;
  logic [DATA_WIDTH-1:0]  drdata_n;

  logic [DEVICE_ADDR_WIDTH-1:0] dev_bits;
  logic [MEM_WIDTH-1:0]         mem_bits;

  // FSM state and bit counter register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, next-counter and next registered output values.
  // Outputs are derived from the *next* state so that they line up with the
  // state they describe (first device bit appears the cycle after accept).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;

    case (state)
      S_IDLE: begin
        if (dvalid) begin
          accept  = 1'b1;
          state_n = S_DADDR;
          cnt_n   = '0;
        end
      end
      S_DADDR: begin
        if (cnt == DEV_LAST) begin
          state_n = S_WACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WACK: begin
        cnt_n = '0;
        if (ack) state_n = S_SADDR;
      end
      S_SADDR: begin
        if (cnt == MEM_LAST) begin
          state_n = mmode ? S_WDATA : S_RDATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WDATA: begin
        if (cnt == DATA_LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RDATA: begin
        // only qualified read bits advance the counter
        if (svalid) begin
          if (cnt == DATA_LAST) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // request capture bypass so the first device bit is available at accept
    addr_n  = accept ? daddr  : addr_q;
    wdata_n = accept ? dwdata : wdata_q;
    mode_n  = accept ? dmode  : mmode;

    dev_bits = addr_n[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH];
    mem_bits = addr_n[MEM_WIDTH-1:0];

    rbuf_n = accept ? '0 : rbuf;
    if (state == S_RDATA && svalid)
      rbuf_n = rbuf | ({{(DATA_WIDTH-1){1'b0}}, mrdata} << cnt);

    mvalid_n = (state_n == S_DADDR) || (state_n == S_SADDR) ||
               (state_n == S_WDATA) || (state_n == S_RDATA);
    dready_n = (state_n == S_IDLE);
    ddone_n  = (state_n == S_DONE);

    case (state_n)
      S_DADDR: mwdata_n = |(dev_bits & (DEVICE_ADDR_WIDTH'(1) << cnt_n));
      S_SADDR: mwdata_n = |(mem_bits & (MEM_WIDTH'(1) << cnt_n));
      S_WDATA: mwdata_n = |(wdata_n  & (DATA_WIDTH'(1) << cnt_n));
      default: mwdata_n = 1'b0;
    endcase

    drdata_n = (state == S_RDATA && state_n == S_DONE) ? rbuf_n : drdata;
  end

  // Request holding registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      mmode   <= 1'b0;
      dready  <= 1'b1;
      ddone   <= 1'b0;
      mvalid  <= 1'b0;
      mwdata  <= 1'b0;
      drdata  <= '0;
    end else begin
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rbuf    <= rbuf_n;
      mmode   <= mode_n;
      dready  <= dready_n;
      ddone   <= ddone_n;
      mvalid  <= mvalid_n;
      mwdata  <= mwdata_n;
      drdata  <= drdata_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_master_port
// Description : Directed self-checking bench for bus_master_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dvalid;
  logic        dmode;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dready;
  logic [7:0]  drdata;
  logic        ddone;
  logic        mwdata;
  logic        mvalid;
  logic        mmode;
  logic        ack;
  logic        mrdata;
  logic        svalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH       (16),
    .DEVICE_ADDR_WIDTH(4),
    .DATA_WIDTH       (8)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .dvalid (dvalid),
    .dmode  (dmode),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dready (dready),
    .drdata (drdata),
    .ddone  (ddone),
    .mwdata (mwdata),
    .mvalid (mvalid),
    .mmode  (mmode),
    .ack    (ack),
    .mrdata (mrdata),
    .svalid (svalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic mode, input logic [15:0] a, input logic [7:0] d);
    check("idle_ready", {31'd0, dready}, 32'd1);
    dvalid = 1'b1;
    dmode  = mode;
    daddr  = a;
    dwdata = d;
    tick();
    dvalid = 1'b0;
    daddr  = 16'h0000;
    dwdata = 8'h00;
  endtask

  // full transaction: ackdly = WACK cycles with ack low before ack is raised
  task automatic xfer(input logic mode, input logic [15:0] a, input logic [7:0] d,
                      input int ackdly, input logic glitch,
                      input logic [7:0] rd, input logic gap);
    int k;
    int n;
    start(mode, a, d);
    check("busy", {31'd0, dready}, 32'd0);
    check("mmode", {31'd0, mmode}, {31'd0, mode});
    for (int i = 0; i < 4; i++) begin
      check("dev_bit", {30'd0, mvalid, mwdata}, {30'd0, 1'b1, a[12+i]});
      tick();
    end
    for (int w = 0; w <= ackdly; w++) begin
      check("wack", {30'd0, mvalid, mwdata}, 32'd0);
      ack = (w == ackdly);
      tick();
    end
    ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("saddr_bit", {30'd0, mvalid, mwdata}, {30'd0, 1'b1, a[i]});
      if (glitch && i == 2) begin
        dvalid = 1'b1;
        daddr  = 16'hFFFF;
      end else begin
        dvalid = 1'b0;
      end
      tick();
    end
    dvalid = 1'b0;
    if (mode) begin
      for (int i = 0; i < 8; i++) begin
        check("wdata_bit", {30'd0, mvalid, mwdata}, {30'd0, 1'b1, d[i]});
        tick();
      end
    end else begin
      k = 0;
      n = 0;
      while (k < 8 && n < 40) begin
        check("rdata_bus", {30'd0, mvalid, mwdata}, 32'd2);
        if (gap && (n % 2 == 1)) begin
          svalid = 1'b0;
          mrdata = ~rd[k];
        end else begin
          svalid = 1'b1;
          mrdata = rd[k];
          k++;
        end
        n++;
        tick();
      end
      svalid = 1'b0;
      mrdata = 1'b0;
      if (k < 8) check("rdata_timeout", k, 8);
    end
    check("ddone", {31'd0, ddone}, 32'd1);
    check("done_mvalid", {31'd0, mvalid}, 32'd0);
    if (!mode) check("drdata", {24'd0, drdata}, {24'd0, rd});
    tick();
    check("ready_after", {31'd0, dready}, 32'd1);
    check("ddone_pulse", {31'd0, ddone}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn   = 1'b0;
    dvalid = 1'b0;
    dmode  = 1'b0;
    daddr  = 16'h0000;
    dwdata = 8'h00;
    ack    = 1'b0;
    mrdata = 1'b0;
    svalid = 1'b0;

    // reset
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("rst_dready", {31'd0, dready}, 32'd1);
    check("rst_mvalid", {31'd0, mvalid}, 32'd0);
    check("rst_ddone",  {31'd0, ddone},  32'd0);
    check("rst_drdata", {24'd0, drdata}, 32'd0);
    check("rst_mwdata", {31'd0, mwdata}, 32'd0);
    check("rst_mmode",  {31'd0, mmode},  32'd0);

    // write with immediate ack
    xfer(1'b1, 16'h1ABC, 8'h5A, 0, 1'b0, 8'h00, 1'b0);

    // write with ack held off for 5 WACK cycles
    xfer(1'b1, 16'h7E81, 8'hA5, 5, 1'b0, 8'h00, 1'b0);

    // read with svalid low on alternate cycles
    xfer(1'b0, 16'h3010, 8'h00, 0, 1'b0, 8'hC3, 1'b1);

    // write with a stray dvalid pulse mid-transaction
    xfer(1'b1, 16'hC3F0, 8'h96, 1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("no_second_txn", {30'd0, mvalid, dready}, 32'd1);
      tick();
    end
    check("drdata_held", {24'd0, drdata}, 32'hC3);

    // reset while shifting the slave address
    start(1'b1, 16'h2345, 8'h11);
    repeat (4) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("saddr_active", {31'd0, mvalid}, 32'd1);
    rstn = 1'b0;
    tick();
    check("abort_mvalid", {31'd0, mvalid}, 32'd0);
    check("abort_dready", {31'd0, dready}, 32'd1);
    check("abort_ddone",  {31'd0, ddone},  32'd0);
    check("abort_drdata", {24'd0, drdata}, 32'd0);
    rstn = 1'b1;

    // following write completes normally
    xfer(1'b1, 16'h2345, 8'h11, 0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_master_port.md
# bus_master_port

Master-side serial port for the system bus. It accepts one parallel read or write request from a local master and serialises the device address onto the single-bit bus for the address decoder. It then waits for the decoder's ack and shifts the slave memory address and write data, or collects serial read data. It sits directly upstream of the address decoder: its `mwdata` and `mvalid` drive the decoder's inputs, and the decoder's `ack` returns to it.

## Interface
- `ADDR_WIDTH`, 16, full request address width; the top `DEVICE_ADDR_WIDTH` bits are the device, the rest are the slave memory address.
- `DEVICE_ADDR_WIDTH`, 4, device address width; must match the decoder.
- `DATA_WIDTH`, 8, data word width.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous, active-low reset.
- `dvalid`  in  1  local request valid.
- `dmode`  in  1  1 = write, 0 = read.
- `daddr`  in  ADDR_WIDTH  request address.
- `dwdata`  in  DATA_WIDTH  write data.
- `dready`  out  1  port idle; a request is accepted when `dvalid & dready`.
- `drdata`  out  DATA_WIDTH  read result, valid while `ddone` is high and held until the next read completes.
- `ddone`  out  1  one-cycle pulse when a transaction completes.
- `mwdata`  out  1  serial write/address bit to the decoder.
- `mvalid`  out  1  bus valid to the decoder.
- `mmode`  out  1  registered `dmode`, held for the whole transaction.
- `ack`  in  1  connection acknowledge from the decoder.
- `mrdata`  in  1  serial read data from the selected slave.
- `svalid`  in  1  qualifies `mrdata`.

## Operation
- All outputs are registered.
- Reset values: `dready`=1, `mvalid`=0, `mwdata`=0, `mmode`=0, `ddone`=0, `drdata`=0, state=IDLE, counter=0.
- States: IDLE, DADDR, WACK, SADDR, WDATA, RDATA, DONE.
- IDLE: `dready`=1. On `dvalid`, capture `daddr`, `dwdata` and `dmode`, clear counter, go to DADDR. `dready` falls the next cycle. `dvalid` while not in IDLE is ignored.
- DADDR: `mvalid`=1 and `mwdata` = device bit[counter], LSB first, for `DEVICE_ADDR_WIDTH` cycles. The device bits are `daddr[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH]`. After the last bit, go to WACK.
- WACK: `mvalid`=0 and `mwdata`=0. The state is held until `ack`=1 is sampled, then go to SADDR. `mvalid` must stay low in WACK so the decoder stays in CONNECT and arms its slave enable.
- SADDR: `mvalid`=1, shifting `ADDR_WIDTH-DEVICE_ADDR_WIDTH` memory-address bits LSB first. Then go to WDATA if write, RDATA if read.
- WDATA: `mvalid`=1, shifting `DATA_WIDTH` data bits LSB first, then go to DONE.
- RDATA: `mvalid`=1 and `mwdata`=0. Each cycle with `svalid`=1 samples `mrdata` into bit[counter], LSB first. Cycles with `svalid`=0 do not advance the counter. After `DATA_WIDTH` valid bits, go to DONE.
- DONE: `mvalid`=0 for exactly one cycle, which returns the decoder to IDLE. `ddone`=1 in this cycle. For reads, `drdata` takes the assembled word on the same edge that raises `ddone`. Go to IDLE.
- Counter width is `$clog2` of the largest of `DEVICE_ADDR_WIDTH`, `ADDR_WIDTH-DEVICE_ADDR_WIDTH` and `DATA_WIDTH`, plus one bit. It resets to 0 on every state change.
- `ack` sampled in any state other than WACK is ignored.
- `svalid` outside RDATA is ignored.
- Reset mid-transaction: all outputs return to their reset values on the next edge. `mvalid` drops, which releases the decoder.

## Timing
- Request accepted at edge T0. The first device bit is on `mwdata` with `mvalid`=1 in the cycle after T0.
- With immediate `ack` and defaults, a write has 4 device + 1 WACK + 12 address + 8 data = 25 bus cycles. `ddone` is high in cycle 26 after T0 and `dready` in cycle 27.
- A read with `svalid` held high has the same count: the 8 RDATA cycles replace the 8 WDATA cycles.
- WACK lasts at least one cycle. `ack` is high in the first WACK cycle when the decoder is compliant.
- There is no back-to-back issue: at least one `mvalid`=0 cycle (DONE) separates transactions.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles, release → `dready`=1, `mvalid`=0, `ddone`=0, `drdata`=0.
- Write `daddr`=0x1ABC, `dwdata`=0x5A, `ack` high in WACK → `mwdata` sequence:
  - device bits 1,0,0,0;
  - one `mvalid`=0 cycle;
  - address bits 0,0,1,1, 1,1,0,1, 0,1,0,1;
  - data bits 0,1,0,1,1,0,1,0;
  - then a `ddone` pulse.
- Delayed `ack`, asserted 5 cycles into WACK → `mvalid` stays 0 for those 5 cycles, and SADDR starts the cycle after `ack` is sampled.
- Read `daddr`=0x3010, slave returns 0xC3 with `svalid` low on alternate cycles → only qualified bits are taken, `drdata`=0xC3 with `ddone`=1, and `mvalid` stays 1 throughout RDATA.
- `dvalid` pulsed mid-transaction → ignored; no second transaction starts.
- `rstn` low during SADDR → the next cycle has `mvalid`=0 and `dready`=1, and a following write completes normally.
